// File: rtl/operand_bypass_gen_pkg.sv
// Shared opcode/funct constants, bus widths and output-stage state type for operand_bypass_gen.
// MIPS-style encodings; every file of the block imports this instead of redefining them.
package operand_bypass_gen_pkg;

  localparam int INST_ADDR_W = 32;
  localparam int OP_W        = 6;
  localparam int FUNCT_W     = 6;
  localparam int IMM_W       = 16;
  localparam int REG_ADDR_W  = 5;
  localparam int STALL_CNT_W = 16;

  localparam logic [OP_W-1:0] OP_SPECIAL   = 6'h00;
  localparam logic [OP_W-1:0] OP_JAL       = 6'h03;
  localparam logic [OP_W-1:0] OP_ADDIU     = 6'h09;
  localparam logic [OP_W-1:0] OP_ANDI      = 6'h0C;
  localparam logic [OP_W-1:0] OP_ORI       = 6'h0D;
  localparam logic [OP_W-1:0] OP_XORI      = 6'h0E;
  localparam logic [OP_W-1:0] OP_LUI       = 6'h0F;
  localparam logic [OP_W-1:0] OP_PRIVILEGE = 6'h10;
  localparam logic [OP_W-1:0] OP_LB        = 6'h20;
  localparam logic [OP_W-1:0] OP_LH        = 6'h21;
  localparam logic [OP_W-1:0] OP_LW        = 6'h23;
  localparam logic [OP_W-1:0] OP_LBU       = 6'h24;
  localparam logic [OP_W-1:0] OP_SB        = 6'h28;
  localparam logic [OP_W-1:0] OP_SW        = 6'h2B;

  localparam logic [FUNCT_W-1:0] FUNCT_JALR = 6'h09;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_state_e;

  // Opcodes whose second operand is the sign-extended immediate.
  function automatic logic is_simm_op(input logic [OP_W-1:0] op);
    return (op == OP_ADDIU) || (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
           (op == OP_LBU)   || (op == OP_SB) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/operand_fwd_mux.sv
// Purpose: pick one register value from the forwarding sources (lowest index wins) or the regfile.
// Latency: combinational. Backpressure: none; o_pending tells the caller the chosen source is not ready.
module operand_fwd_mux
  import operand_bypass_gen_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int NUM_FWD = 2
) (
  input  logic [REG_ADDR_W-1:0]         i_reg_addr,
  input  logic [DATA_W-1:0]             i_reg_data,
  input  logic [NUM_FWD-1:0]            i_fwd_valid,
  input  logic [NUM_FWD-1:0]            i_fwd_pending,
  input  logic [REG_ADDR_W*NUM_FWD-1:0] i_fwd_addr,
  input  logic [DATA_W*NUM_FWD-1:0]     i_fwd_data,
  output logic [DATA_W-1:0]             o_val,
  output logic                          o_pending
);

  always_comb begin
    o_val     = i_reg_data;
    o_pending = 1'b0;
    // Walk oldest to youngest so the youngest match is the one left standing.
    for (int i = NUM_FWD - 1; i >= 0; i--) begin
      if (i_fwd_valid[i] && (i_fwd_addr[i*REG_ADDR_W +: REG_ADDR_W] == i_reg_addr)) begin
        o_val     = i_fwd_data[i*DATA_W +: DATA_W];
        o_pending = i_fwd_pending[i];
      end
    end
    if (i_reg_addr == '0) begin
      o_val     = '0;
      o_pending = 1'b0;
    end
  end

endmodule

// File: rtl/operand_bypass_gen.sv
// Purpose: build execute operands from decode fields with register forwarding; OPGEN_STALL_CNT_EN adds a hazard-stall counter.
// Latency: 1 cycle accept-to-out_valid, full throughput. Backpressure: in_ready drops on hazard, flush, or held output.
module operand_bypass_gen
  import operand_bypass_gen_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int NUM_FWD     = 2,
  parameter int LINK_OFFSET = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [INST_ADDR_W-1:0]        addr,
  input  logic [OP_W-1:0]               op,
  input  logic [FUNCT_W-1:0]            funct,
  input  logic [IMM_W-1:0]              imm,
  input  logic [REG_ADDR_W-1:0]         rs_addr,
  input  logic [REG_ADDR_W-1:0]         rt_addr,
  input  logic                          inst_mfc0,
  input  logic                          inst_mtc0,
  input  logic [DATA_W-1:0]             reg_data_1,
  input  logic [DATA_W-1:0]             reg_data_2,
  input  logic [DATA_W-1:0]             cp_read_data,
  input  logic [NUM_FWD-1:0]            fwd_valid,
  input  logic [NUM_FWD-1:0]            fwd_pending,
  input  logic [REG_ADDR_W*NUM_FWD-1:0] fwd_addr,
  input  logic [DATA_W*NUM_FWD-1:0]     fwd_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_W-1:0]             operand_1,
  output logic [DATA_W-1:0]             operand_2,
  output logic [STALL_CNT_W-1:0]        stall_cnt
);

  logic [DATA_W-1:0]      w_rs_val, w_rt_val;
  logic                   w_rs_pend, w_rt_pend;
  logic                   w_rs_used, w_rt_used;
  logic                   w_hazard, w_accept;
  logic [INST_ADDR_W-1:0] w_link;
  logic [DATA_W-1:0]      w_op1, w_op2, w_simm, w_zimm, w_uimm;

  out_state_e             r_state;
  logic                   r_out_valid;
  logic [DATA_W-1:0]      r_op1, r_op2;

  operand_fwd_mux #(.DATA_W(DATA_W), .NUM_FWD(NUM_FWD)) u_rs_mux (
    .i_reg_addr   (rs_addr),
    .i_reg_data   (reg_data_1),
    .i_fwd_valid  (fwd_valid),
    .i_fwd_pending(fwd_pending),
    .i_fwd_addr   (fwd_addr),
    .i_fwd_data   (fwd_data),
    .o_val        (w_rs_val),
    .o_pending    (w_rs_pend)
  );

  operand_fwd_mux #(.DATA_W(DATA_W), .NUM_FWD(NUM_FWD)) u_rt_mux (
    .i_reg_addr   (rt_addr),
    .i_reg_data   (reg_data_2),
    .i_fwd_valid  (fwd_valid),
    .i_fwd_pending(fwd_pending),
    .i_fwd_addr   (fwd_addr),
    .i_fwd_data   (fwd_data),
    .o_val        (w_rt_val),
    .o_pending    (w_rt_pend)
  );

  assign w_link = addr + INST_ADDR_W'(LINK_OFFSET);
  assign w_simm = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
  assign w_zimm = {{(DATA_W-IMM_W){1'b0}}, imm};
  assign w_uimm = DATA_W'({imm, 16'h0000});

  // The *_used flags keep a pending source from stalling an instruction that ignores that register.
  always_comb begin
    w_op1     = '0;
    w_op2     = '0;
    w_rs_used = 1'b0;
    w_rt_used = 1'b0;
    if (is_simm_op(op)) begin
      w_op1     = w_rs_val;
      w_op2     = w_simm;
      w_rs_used = 1'b1;
    end else begin
      case (op)
        OP_LUI: begin
          w_op1     = w_rs_val;
          w_op2     = w_uimm;
          w_rs_used = 1'b1;
        end
        OP_ANDI, OP_ORI, OP_XORI: begin
          w_op1     = w_rs_val;
          w_op2     = w_zimm;
          w_rs_used = 1'b1;
        end
        OP_SPECIAL: begin
          if (funct == FUNCT_JALR) begin
            w_op1 = DATA_W'(w_link);
          end else begin
            w_op1     = w_rs_val;
            w_rs_used = 1'b1;
          end
          w_op2     = w_rt_val;
          w_rt_used = 1'b1;
        end
        OP_JAL: w_op1 = DATA_W'(w_link);
        OP_PRIVILEGE: begin
          w_op1     = inst_mfc0 ? cp_read_data : '0;
          w_op2     = inst_mtc0 ? w_rt_val : '0;
          w_rt_used = inst_mtc0;
        end
        default: ;
      endcase
    end
  end

  assign w_hazard = (w_rs_used && w_rs_pend) || (w_rt_used && w_rt_pend);
  assign in_ready = !w_hazard && (!r_out_valid || out_ready) && !flush;
  assign w_accept = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_EMPTY;
      r_out_valid <= 1'b0;
      r_op1       <= '0;
      r_op2       <= '0;
    end else if (flush) begin
      r_state     <= ST_EMPTY;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            r_state     <= ST_FULL;
            r_out_valid <= 1'b1;
            r_op1       <= w_op1;
            r_op2       <= w_op2;
          end
        end
        ST_FULL: begin
          if (out_ready) begin
            if (w_accept) begin
              r_op1 <= w_op1;
              r_op2 <= w_op2;
            end else begin
              r_state     <= ST_EMPTY;
              r_out_valid <= 1'b0;
            end
          end
        end
        default: begin
          r_state     <= ST_EMPTY;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid = r_out_valid;
  assign operand_1 = r_op1;
  assign operand_2 = r_op2;

`ifdef OPGEN_STALL_CNT_EN
  logic [STALL_CNT_W-1:0] r_stall_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (in_valid && w_hazard && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + STALL_CNT_W'(1);
    end
  end

  assign stall_cnt = r_stall_cnt;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_operand_bypass_gen.sv
// Directed bench for operand_bypass_gen: inputs change 1ns after posedge, outputs are checked on negedge.
module tb_operand_bypass_gen;
  import operand_bypass_gen_pkg::*;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready;
  logic [31:0] addr;
  logic [5:0]  op, funct;
  logic [15:0] imm;
  logic [4:0]  rs_addr, rt_addr;
  logic        inst_mfc0, inst_mtc0;
  logic [31:0] reg_data_1, reg_data_2, cp_read_data;
  logic [1:0]  fwd_valid, fwd_pending;
  logic [9:0]  fwd_addr;
  logic [63:0] fwd_data;
  logic        out_valid, out_ready;
  logic [31:0] operand_1, operand_2;
  logic [15:0] stall_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  operand_bypass_gen dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .addr(addr), .op(op), .funct(funct), .imm(imm), .rs_addr(rs_addr), .rt_addr(rt_addr),
    .inst_mfc0(inst_mfc0), .inst_mtc0(inst_mtc0), .reg_data_1(reg_data_1),
    .reg_data_2(reg_data_2), .cp_read_data(cp_read_data), .fwd_valid(fwd_valid),
    .fwd_pending(fwd_pending), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
    .out_valid(out_valid), .out_ready(out_ready), .operand_1(operand_1),
    .operand_2(operand_2), .stall_cnt(stall_cnt)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    flush = 0; in_valid = 0; addr = 0; op = 6'h3F; funct = 0; imm = 0;
    rs_addr = 0; rt_addr = 0; inst_mfc0 = 0; inst_mtc0 = 0;
    reg_data_1 = 0; reg_data_2 = 0; cp_read_data = 0;
    fwd_valid = 0; fwd_pending = 0; fwd_addr = 0; fwd_data = 0; out_ready = 1;
  endtask

  // Present the currently driven instruction for exactly one edge.
  task automatic issue();
    in_valid = 1;
    cyc();
    in_valid = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    cyc(); cyc();
    rst = 0;
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    n_checks++; if (operand_1 !== 32'h0) begin n_fail++; $display("FAIL reset_op1 got=%h exp=0", operand_1); end
    n_checks++; if (operand_2 !== 32'h0) begin n_fail++; $display("FAIL reset_op2 got=%h exp=0", operand_2); end
    n_checks++; if (stall_cnt !== 16'h0) begin n_fail++; $display("FAIL reset_stall_cnt got=%h exp=0", stall_cnt); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    cyc();
  endtask

  task automatic test_immediates();
    idle_inputs();
    op = OP_ADDIU; rs_addr = 3; reg_data_1 = 32'h10; imm = 16'hFFFF;
    issue();
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL addiu_valid got=%b exp=1", out_valid); end
    n_checks++; if (operand_1 !== 32'h10) begin n_fail++; $display("FAIL addiu_op1 got=%h exp=00000010", operand_1); end
    n_checks++; if (operand_2 !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL addiu_op2 got=%h exp=ffffffff", operand_2); end
    op = OP_ANDI;
    cyc(); issue();
    @(negedge clk);
    n_checks++; if (operand_2 !== 32'h0000FFFF) begin n_fail++; $display("FAIL andi_zext got=%h exp=0000ffff", operand_2); end
    op = OP_LUI; imm = 16'h1234;
    cyc(); issue();
    @(negedge clk);
    n_checks++; if (operand_1 !== 32'h10) begin n_fail++; $display("FAIL lui_op1 got=%h exp=00000010", operand_1); end
    n_checks++; if (operand_2 !== 32'h12340000) begin n_fail++; $display("FAIL lui_op2 got=%h exp=12340000", operand_2); end
    op = 6'h3F;
    cyc(); issue();
    @(negedge clk);
    n_checks++; if ({operand_1, operand_2} !== 64'h0) begin n_fail++; $display("FAIL other_op got=%h/%h exp=0/0", operand_1, operand_2); end
    cyc();
  endtask

  task automatic test_forward_priority();
    idle_inputs();
    op = OP_SPECIAL; funct = 6'h21; rs_addr = 5; rt_addr = 6;
    reg_data_1 = 32'h55; reg_data_2 = 32'h66;
    fwd_valid = 2'b11; fwd_addr = {5'd5, 5'd5}; fwd_data = {32'hB, 32'hA};
    issue();
    @(negedge clk);
    n_checks++; if (operand_1 !== 32'hA) begin n_fail++; $display("FAIL fwd_youngest got=%h exp=0000000a", operand_1); end
    n_checks++; if (operand_2 !== 32'h66) begin n_fail++; $display("FAIL fwd_rt_regfile got=%h exp=00000066", operand_2); end
    fwd_valid = 2'b10;
    cyc(); issue();
    @(negedge clk);
    n_checks++; if (operand_1 !== 32'hB) begin n_fail++; $display("FAIL fwd_older got=%h exp=0000000b", operand_1); end
    rs_addr = 0; fwd_valid = 2'b11; fwd_addr = 10'd0;
    cyc(); issue();
    @(negedge clk);
    n_checks++; if (operand_1 !== 32'h0) begin n_fail++; $display("FAIL fwd_r0 got=%h exp=0", operand_1); end
    cyc();
  endtask

  task automatic test_hazard();
    logic [15:0] exp_cnt;
`ifdef OPGEN_STALL_CNT_EN
    exp_cnt = 16'd3;
`else
    exp_cnt = 16'd0;
`endif
    idle_inputs();
    op = OP_ADDIU; rs_addr = 3; rt_addr = 7;
    fwd_valid = 2'b01; fwd_pending = 2'b01; fwd_addr = {5'd0, 5'd7};
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL unused_rt_no_stall got=%b exp=1", in_ready); end
    op = OP_LW; rs_addr = 7; rt_addr = 0; imm = 16'h0004; fwd_data = {32'h0, 32'h77};
    in_valid = 1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL hazard_in_ready[%0d] got=%b exp=0", k, in_ready); end
      cyc();
    end
    fwd_pending = 2'b00; fwd_data = {32'h0, 32'h1234};
    @(negedge clk);
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL hazard_release got=%b exp=1", in_ready); end
    n_checks++; if (stall_cnt !== exp_cnt) begin n_fail++; $display("FAIL stall_cnt got=%0d exp=%0d", stall_cnt, exp_cnt); end
    cyc();
    in_valid = 0;
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL hazard_out_valid got=%b exp=1", out_valid); end
    n_checks++; if (operand_1 !== 32'h1234) begin n_fail++; $display("FAIL hazard_op1 got=%h exp=00001234", operand_1); end
    n_checks++; if (operand_2 !== 32'h4) begin n_fail++; $display("FAIL hazard_op2 got=%h exp=00000004", operand_2); end
    cyc();
  endtask

  task automatic test_link_priv();
    idle_inputs();
    op = OP_SPECIAL; funct = FUNCT_JALR; addr = 32'hFFFFFFFC;
    issue();
    @(negedge clk);
    n_checks++; if (operand_1 !== 32'h4) begin n_fail++; $display("FAIL jalr_wrap got=%h exp=00000004", operand_1); end
    op = OP_JAL; funct = 0; addr = 32'h400; rt_addr = 2; reg_data_2 = 32'h22;
    cyc(); issue();
    @(negedge clk);
    n_checks++; if (operand_1 !== 32'h408) begin n_fail++; $display("FAIL jal_op1 got=%h exp=00000408", operand_1); end
    n_checks++; if (operand_2 !== 32'h0) begin n_fail++; $display("FAIL jal_op2 got=%h exp=0", operand_2); end
    op = OP_PRIVILEGE; inst_mfc0 = 1; cp_read_data = 32'hC0C0;
    cyc(); issue();
    @(negedge clk);
    n_checks++; if ({operand_1, operand_2} !== {32'hC0C0, 32'h0}) begin n_fail++; $display("FAIL mfc0 got=%h/%h exp=0000c0c0/0", operand_1, operand_2); end
    inst_mfc0 = 0; inst_mtc0 = 1;
    cyc(); issue();
    @(negedge clk);
    n_checks++; if ({operand_1, operand_2} !== {32'h0, 32'h22}) begin n_fail++; $display("FAIL mtc0 got=%h/%h exp=0/00000022", operand_1, operand_2); end
    cyc();
  endtask

  task automatic test_backpressure_flush();
    idle_inputs();
    op = OP_ADDIU; rs_addr = 3; reg_data_1 = 32'h10; imm = 16'h0001; out_ready = 0;
    in_valid = 1;
    cyc();
    op = OP_ORI; reg_data_1 = 32'h20; imm = 16'hAAAA;
    for (int k = 1; k <= 2; k++) begin
      if (k == 2) flush = 1;
      @(negedge clk);
      n_checks++; if ({out_valid, in_ready} !== 2'b10) begin n_fail++; $display("FAIL hold_vld_rdy[%0d] got=%b exp=10", k, {out_valid, in_ready}); end
      n_checks++; if ({operand_1, operand_2} !== {32'h10, 32'h1}) begin n_fail++; $display("FAIL hold_ops[%0d] got=%h/%h exp=10/1", k, operand_1, operand_2); end
      cyc();
    end
    flush = 0;
    @(negedge clk);
    n_checks++; if ({out_valid, in_ready} !== 2'b01) begin n_fail++; $display("FAIL flush_clears got=%b exp=01", {out_valid, in_ready}); end
    cyc();
    @(negedge clk);
    n_checks++; if ({out_valid, operand_1, operand_2} !== {1'b1, 32'h20, 32'hAAAA}) begin n_fail++; $display("FAIL post_flush_accept got=%b %h/%h exp=1 20/aaaa", out_valid, operand_1, operand_2); end
    in_valid = 0; out_ready = 1;
    cyc();
    flush = 1; in_valid = 1; op = OP_ADDIU; imm = 16'h0005;
    cyc();
    flush = 0; in_valid = 0;
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_wins got=%b exp=0", out_valid); end
    cyc();
  endtask

  task automatic test_back_to_back();
    idle_inputs();
    op = OP_ADDIU; rs_addr = 3; reg_data_1 = 32'h10;
    in_valid = 1;
    for (int k = 1; k <= 3; k++) begin
      imm = 16'(k);
      cyc();
      if (k == 3) in_valid = 0;
      @(negedge clk);
      n_checks++; if ({out_valid, operand_2} !== {1'b1, 32'(k)}) begin n_fail++; $display("FAIL b2b[%0d] got=%b/%h exp=1/%h", k, out_valid, operand_2, 32'(k)); end
    end
    cyc();
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_reset_mid();
    idle_inputs();
    op = OP_ADDIU; rs_addr = 3; reg_data_1 = 32'h10; imm = 16'h0001; out_ready = 0;
    cyc(); issue();
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL pre_rst_full got=%b exp=1", out_valid); end
    rst = 1;
    cyc();
    rst = 0;
    @(negedge clk);
    n_checks++; if ({out_valid, operand_1, operand_2, stall_cnt} !== 81'h0) begin n_fail++; $display("FAIL mid_rst got=%b %h/%h cnt=%h exp=0", out_valid, operand_1, operand_2, stall_cnt); end
    out_ready = 1;
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    test_reset();
    test_immediates();
    test_forward_priority();
    test_hazard();
    test_link_priv();
    test_backpressure_flush();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/operand_bypass_gen.md
OPERAND_BYPASS_GEN -- requirements
Module: operand_bypass_gen

Interface
REQ-001 SHALL have parameter DATA_W, default 32, operand/data width.
REQ-002 SHALL have parameter NUM_FWD, default 2, number of forwarding sources; index 0 is the youngest.
REQ-003 SHALL have parameter LINK_OFFSET, default 8, added to addr to form the link address.
REQ-004 SHALL have ports:
- clk  in  1  clock
- rst  in  1  reset; one clock, synchronous, active-high
- flush  in  1  discard the held output
- in_valid / in_ready  in / out  1 / 1  decode-side handshake
- addr  in  32  instruction address
- op / funct  in  6 / 6  opcode and funct fields
- imm  in  16  immediate field
- rs_addr / rt_addr  in  5 / 5  source register numbers
- inst_mfc0 / inst_mtc0  in  1 / 1  privilege decode
- reg_data_1 / reg_data_2  in  DATA_W  regfile read data
- cp_read_data  in  DATA_W  CP0 read data
- fwd_valid / fwd_pending  in  NUM_FWD  source writes a register / its data is not yet available
- fwd_addr  in  5*NUM_FWD  destination register numbers
- fwd_data  in  DATA_W*NUM_FWD  forwarded data
- out_valid / out_ready  out / in  1 / 1  execute-side handshake
- operand_1 / operand_2  out  DATA_W  registered operands
- stall_cnt  out  16  hazard-stall counter

Function
REQ-005 rs_val/rt_val SHALL come from the lowest-index source with fwd_valid=1 and a matching fwd_addr, else from the regfile; register 0 always reads 0 and is never forwarded.
REQ-006 operand_1 SHALL be:
- rs_val for ADDIU, LUI, ANDI, ORI, XORI, LB, LH, LW, LBU, SB, SW
- SPECIAL: addr+LINK_OFFSET when funct=JALR, else rs_val
- JAL: addr+LINK_OFFSET
- PRIVILEGE: cp_read_data when inst_mfc0, else 0
- all other opcodes: 0
REQ-007 operand_2 SHALL be:
- LUI: {imm,16'b0}
- ADDIU, LB, LH, LW, LBU, SB, SW: sign-extended imm
- ANDI, ORI, XORI: zero-extended imm
- SPECIAL: rt_val
- PRIVILEGE: rt_val when inst_mtc0, else 0
- all other opcodes: 0
REQ-008 Immediate extension SHALL be to DATA_W, and the link address SHALL wrap modulo 2^32.
REQ-009 hazard SHALL be 1 when the source selected for a register operand that is actually used has fwd_pending=1.
REQ-010 in_ready SHALL equal !hazard && (!out_valid || out_ready).
REQ-011 Output register states:
- EMPTY to FULL on in_valid && in_ready, capturing the operands.
- FULL holds while out_ready=0.
- FULL with out_ready=1 reloads when accepting a new input, else goes to EMPTY.
REQ-012 Latency SHALL be 1 cycle from acceptance to out_valid, with full throughput when there is no hazard.
REQ-013 flush SHALL clear out_valid next cycle, SHALL block acceptance that cycle, and SHALL win over simultaneous acceptance.
REQ-014 Outputs SHALL remain stable while out_valid && !out_ready.

Reset
REQ-015 On rst, out_valid=0, operand_1=0, operand_2=0, stall_cnt=0, state=EMPTY.
REQ-016 rst asserted mid-operation SHALL drop any held output without handshake.

Configuration
REQ-017 With OPGEN_STALL_CNT_EN defined, stall_cnt SHALL increment each cycle in_valid && hazard, saturating at 16'hFFFF, and clearing on rst only.
REQ-018 Without OPGEN_STALL_CNT_EN, stall_cnt SHALL be tied to 0 and no counter logic is built.

Structure
REQ-019 Opcode and funct constants and bus widths SHALL come from the shared opcode, funct and bus definition headers; no local duplicates.
REQ-020 The per-register priority match SHALL be a sub-module, operand_fwd_mux, instantiated twice (rs, rt).

Verification
REQ-021 ADDIU, rs=3 with reg=0x10, imm=0xFFFF, no forwarding -> one cycle later out_valid=1, op1=0x10, op2=0xFFFFFFFF.
REQ-022 SPECIAL, rs=5, fwd0 and fwd1 both valid for r5 with data 0xA / 0xB -> op1=0xA; with rs=0 -> op1=0.
REQ-023 LW, rs=7, fwd0 matching r7 with pending=1 for 3 cycles -> in_ready=0 for 3 cycles, stall_cnt=3 with macro defined, then operand captured from the forwarded data.
REQ-024 JALR with addr=0xFFFFFFFC -> op1=0x00000004; JAL with addr=0x400 -> op1=0x408, op2=0.
REQ-025 out_ready=0 for 4 cycles with in_valid held -> outputs stable, in_ready=0; flush in cycle 2 -> out_valid=0 next cycle.
REQ-026 rst pulse while FULL -> out_valid=0 and operands 0 on the following cycle.
